// File: rtl/sr_alu_bist_if.sv
// sr_alu_bist_if: operand/opcode bus between the ALU BIST driver and the ALU.
interface sr_alu_bist_if;
  logic [31:0] alu_srcA;
  logic [31:0] alu_srcB;
  logic [2:0]  alu_oper;
  logic [31:0] alu_result;
  logic        alu_zero;
  modport master (output alu_srcA, alu_srcB, alu_oper, input alu_result, alu_zero);
  modport slave  (input alu_srcA, alu_srcB, alu_oper, output alu_result, alu_zero);
endinterface

// File: rtl/sr_alu_bist.sv
// sr_alu_bist: LFSR operand generator and MISR compactor for schoolRISCV ALU self-test.
// Optional zero-flag check enabled by defining SR_ALU_BIST_ZERO_CHECK_EN.
module sr_alu_bist #(
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_1234,
  parameter logic [31:0] GOLDEN      = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [31:0]         signature,
  output logic                err_zero,
  sr_alu_bist_if.master       alu
);
  localparam int CW = $clog2(NUM_VECTORS + 1);
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_OR = 3'b001, ALU_SRL = 3'b010,
                         ALU_SLTU = 3'b011, ALU_SUB = 3'b100;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003, MISR_POLY = 32'h0040_0007;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_idx;
  logic [31:0]     lfsr_a, lfsr_b;
  logic            load, last;
  assign load = start && state != RUN;
  assign last = cnt == CW'(NUM_VECTORS - 1);
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nxt;
  always_comb
    state_nxt = load ? RUN : (state == RUN && last) ? DONE : state;
  always_comb begin
    busy          = state == RUN;
    done          = state == DONE;
    pass          = done && signature == GOLDEN && !err_zero;
    alu.alu_srcA  = lfsr_a;
    alu.alu_srcB  = lfsr_b;
    alu.alu_oper  = op_idx == 3'd1 ? ALU_OR :
                    op_idx == 3'd2 ? ALU_SRL :
                    op_idx == 3'd3 ? ALU_SLTU :
                    op_idx == 3'd4 ? ALU_SUB : ALU_ADD;
  end
  // operands and opcode freeze on the last vector so they hold through DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_a    <= '0;
      lfsr_b    <= '0;
      signature <= '0;
      cnt       <= '0;
      op_idx    <= '0;
    end else if (load) begin
      lfsr_a    <= SEED;
      lfsr_b    <= ~SEED;
      signature <= '0;
      cnt       <= '0;
      op_idx    <= '0;
    end else if (state == RUN) begin
      signature <= {signature[30:0], 1'b0} ^ (signature[31] ? MISR_POLY : 32'h0) ^ alu.alu_result;
      cnt       <= cnt + 1'b1;
      if (!last) begin
        lfsr_a <= (lfsr_a >> 1) ^ (lfsr_a[0] ? LFSR_POLY : 32'h0);
        lfsr_b <= (lfsr_b >> 1) ^ (lfsr_b[0] ? LFSR_POLY : 32'h0);
        op_idx <= op_idx == 3'd4 ? 3'd0 : op_idx + 3'd1;
      end
    end
  end
`ifdef SR_ALU_BIST_ZERO_CHECK_EN
  always_ff @(posedge clk)
    if (!rst_n || load) err_zero <= 1'b0;
    else if (state == RUN && alu.alu_zero != (alu.alu_result == 32'h0)) err_zero <= 1'b1;
`else
  assign err_zero = 1'b0;
`endif
endmodule

// File: tb/tb_sr_alu_bist.sv
// tb_sr_alu_bist: directed vectors for sr_alu_bist driving a behavioural schoolRISCV ALU.
module tb_sr_alu_bist;
  localparam logic [31:0] SEED = 32'hACE1_1234;
  localparam int N1 = 7, N2 = 20;
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a | b;
      3'd2: alu_f = a >> b[4:0];
      3'd3: alu_f = {31'b0, a < b};
      3'd4: alu_f = a - b;
      default: alu_f = 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] model_sig(input int n, input logic fault);
    logic [31:0] a, b, s, r;
    logic [2:0] op;
    a = SEED; b = ~SEED; s = 32'h0;
    for (int i = 0; i < n; i++) begin
      op = 3'(i % 5);
      r = alu_f(op, a, b);
      if (fault && op == 3'd2) r[0] = 1'b1;
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0) ^ r;
      a = (a >> 1) ^ (a[0] ? 32'h8020_0003 : 32'h0);
      b = (b >> 1) ^ (b[0] ? 32'h8020_0003 : 32'h0);
    end
    model_sig = s;
  endfunction
  localparam logic [31:0] GOLD1 = model_sig(N1, 1'b0);
  localparam logic [31:0] GOLD2 = model_sig(N2, 1'b0);
  localparam logic [31:0] FSIG2 = model_sig(N2, 1'b1);
  logic clk = 1'b0, rst_n = 1'b0, start1 = 1'b0, start2 = 1'b0, fault = 1'b0, zforce = 1'b0;
  logic busy1, done1, pass1, err1, busy2, done2, pass2, err2;
  logic [31:0] sig1, sig2, r1, r2;
  int checks = 0, errors = 0, n;
  sr_alu_bist_if a1 ();
  sr_alu_bist_if a2 ();
  always #5 clk = ~clk;
  always_comb begin
    r1 = alu_f(a1.alu_oper, a1.alu_srcA, a1.alu_srcB);
    a1.alu_result = r1;
    a1.alu_zero = (r1 == 32'h0) ^ zforce;
  end
  always_comb begin
    r2 = alu_f(a2.alu_oper, a2.alu_srcA, a2.alu_srcB);
    if (fault && a2.alu_oper == 3'd2) r2[0] = 1'b1;
    a2.alu_result = r2;
    a2.alu_zero = r2 == 32'h0;
  end
  sr_alu_bist #(.NUM_VECTORS(N1), .SEED(SEED), .GOLDEN(GOLD1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1), .err_zero(err1), .alu(a1.master));
  sr_alu_bist #(.NUM_VECTORS(N2), .SEED(SEED), .GOLDEN(GOLD2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .signature(sig2), .err_zero(err2), .alu(a2.master));
  typedef struct {
    logic [2:0]  oper;
    logic [31:0] a;
    logic [31:0] b;
    logic        chk_ab;
  } vec_t;
  vec_t tbl [N1];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle1(input int limit);
    n = 0;
    while (busy1 && n < limit) begin
      n++;
      tick();
    end
  endtask
  initial begin
    tbl[0] = '{3'd0, 32'hACE1_1234, 32'h531E_EDCB, 1'b1};
    tbl[1] = '{3'd1, 32'h5670_891A, 32'hA9AF_76E6, 1'b1};
    tbl[2] = '{3'd2, 32'h2B38_448D, 32'h54D7_BB73, 1'b1};
    tbl[3] = '{3'd3, 32'h95BC_2245, 32'hAA4B_DDBA, 1'b1};
    tbl[4] = '{3'd4, 32'h0, 32'h0, 1'b0};
    tbl[5] = '{3'd0, 32'h0, 32'h0, 1'b0};
    tbl[6] = '{3'd1, 32'h0, 32'h0, 1'b0};
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_busy", busy1, 0); chk("rst_done", done1, 0); chk("rst_pass", pass1, 0);
    chk("rst_sig", sig1, 0); chk("rst_srcA", a1.alu_srcA, 0); chk("rst_srcB", a1.alu_srcB, 0);
    chk("rst_oper", a1.alu_oper, 0); chk("rst_err", err1, 0);
    // basic run against the vector table
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 0; i < N1; i++) begin
      chk($sformatf("oper[%0d]", i), a1.alu_oper, tbl[i].oper);
      chk($sformatf("busy[%0d]", i), busy1, 1);
      chk($sformatf("done[%0d]", i), done1, 0);
      if (tbl[i].chk_ab) begin
        chk($sformatf("srcA[%0d]", i), a1.alu_srcA, tbl[i].a);
        chk($sformatf("srcB[%0d]", i), a1.alu_srcB, tbl[i].b);
      end
      tick();
    end
    chk("run_done", done1, 1); chk("run_busy", busy1, 0); chk("run_sig", sig1, GOLD1);
    chk("run_pass", pass1, 1); chk("hold_oper", a1.alu_oper, 3'd1); chk("run_err", err1, 0);
    tick(); tick();
    chk("done_hold", done1, 1); chk("done_sig_hold", sig1, GOLD1);
    // starts during RUN are ignored
    start1 = 1'b1; tick(); start1 = 1'b0;
    n = 0;
    while (busy1 && n < 50) begin
      start1 = (n == 3 || n == 5);
      n++;
      tick();
    end
    start1 = 1'b0;
    chk("ign_len", n, N1); chk("ign_done", done1, 1); chk("rerun_sig", sig1, GOLD1); chk("rerun_pass", pass1, 1);
    // start held high restarts straight out of DONE
    start1 = 1'b1; tick();
    wait_idle1(50);
    chk("held_len", n, N1); chk("held_done", done1, 1);
    tick();
    chk("held_restart", busy1, 1); chk("held_pass0", pass1, 0);
    start1 = 1'b0;
    wait_idle1(50);
    chk("held_done2", done1, 1); chk("held_sig", sig1, GOLD1);
    // reset mid-run
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick(); tick();
    chk("mid_busy", busy1, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mrst_busy", busy1, 0); chk("mrst_done", done1, 0); chk("mrst_pass", pass1, 0);
    chk("mrst_sig", sig1, 0); chk("mrst_srcA", a1.alu_srcA, 0);
    tick();
    chk("mrst_idle", busy1, 0);
    // stuck-at-1 on bit 0 of SRL results
    fault = 1'b1; start2 = 1'b1; tick(); start2 = 1'b0;
    n = 0;
    while (busy2 && n < 100) begin n++; tick(); end
    chk("flt_len", n, N2); chk("flt_done", done2, 1); chk("flt_sig", sig2, FSIG2);
    chk("flt_pass", pass2, (FSIG2 == GOLD2) ? 1 : 0);
    fault = 1'b0; start2 = 1'b1; tick(); start2 = 1'b0;
    n = 0;
    while (busy2 && n < 100) begin n++; tick(); end
    chk("ok2_sig", sig2, GOLD2); chk("ok2_pass", pass2, 1); chk("ok2_err", err2, 0);
`ifdef SR_ALU_BIST_ZERO_CHECK_EN
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 0; i < N1; i++) begin
      zforce = (i == 2);
      tick();
      zforce = 1'b0;
      chk($sformatf("zerr[%0d]", i), err1, (i >= 2) ? 1 : 0);
    end
    chk("z_done", done1, 1); chk("z_pass", pass1, 0); chk("z_sig", sig1, GOLD1);
    start1 = 1'b1; tick(); start1 = 1'b0;
    chk("z_clear", err1, 0);
    wait_idle1(50);
    chk("z_pass2", pass1, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
